// File: rtl/traffic_light_controller_param.sv
// Highway/farm-road intersection controller with programmable phase timing,
// all-red clearance, latched pedestrian walk and emergency highway priority.
module traffic_light_controller_param #(
    parameter int unsigned HWY_MIN_GREEN  = 20,
    parameter int unsigned HWY_YELLOW     = 3,
    parameter int unsigned FARM_MAX_GREEN = 10,
    parameter int unsigned FARM_YELLOW    = 3,
    parameter int unsigned ALL_RED        = 1,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        HGRE  = 3'd0,
        HYEL  = 3'd1,
        ARED1 = 3'd2,
        FGRE  = 3'd3,
        FYEL  = 3'd4,
        ARED2 = 3'd5
    } state_e;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] HY_LAST  = CNT_W'(HWY_YELLOW - 1);
    localparam logic [CNT_W-1:0] FG_LAST  = CNT_W'(FARM_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] FY_LAST  = CNT_W'(FARM_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic             ped_walk_q, ped_walk_d;
    logic [2:0]       hwy_q, hwy_d;
    logic [2:0]       farm_q, farm_d;
    logic             enter_fgre;

    // Next-state, counter, pedestrian latch and light decode of the next state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ped_pending_d = ped_pending_q;
        ped_walk_d    = 1'b0;
        hwy_d         = LIGHT_RED;
        farm_d        = LIGHT_RED;
        enter_fgre    = 1'b0;

        case (state_q)
            HGRE: begin
                if ((cnt_q >= HG_LAST) && (sensor || ped_pending_q) && !emergency)
                    state_d = HYEL;
            end
            HYEL: begin
                if (cnt_q == HY_LAST) state_d = ARED1;
            end
            ARED1: begin
                if (cnt_q == AR_LAST) state_d = emergency ? HGRE : FGRE;
            end
            FGRE: begin
                // A walk visit is held for the full farm green so the crossing completes
                if (emergency || (cnt_q == FG_LAST) ||
                    (!sensor && !ped_pending_q && !ped_walk_q && (cnt_q != '0)))
                    state_d = FYEL;
            end
            FYEL: begin
                if (cnt_q == FY_LAST) state_d = ARED2;
            end
            ARED2: begin
                if (cnt_q == AR_LAST) state_d = HGRE;
            end
            default: state_d = HGRE;
        endcase

        if (state_d != state_q)       cnt_d = '0;
        else if (cnt_q != CNT_MAX)    cnt_d = cnt_q + CNT_W'(1);

        enter_fgre = (state_d == FGRE) && (state_q != FGRE);
        if (enter_fgre)               ped_walk_d = ped_pending_q;
        else if (state_d == FGRE)     ped_walk_d = ped_walk_q;

        // A request arriving on the clearing cycle survives
        if (ped_req)                  ped_pending_d = 1'b1;
        else if (enter_fgre)          ped_pending_d = 1'b0;

        case (state_d)
            HGRE:    hwy_d  = LIGHT_GREEN;
            HYEL:    hwy_d  = LIGHT_YELLOW;
            FGRE:    farm_d = LIGHT_GREEN;
            FYEL:    farm_d = LIGHT_YELLOW;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HGRE;
            cnt_q         <= '0;
            ped_pending_q <= 1'b0;
            ped_walk_q    <= 1'b0;
            hwy_q         <= LIGHT_GREEN;
            farm_q        <= LIGHT_RED;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            ped_walk_q    <= ped_walk_d;
            hwy_q         <= hwy_d;
            farm_q        <= farm_d;
        end
    end

    assign light_highway = hwy_q;
    assign light_farm    = farm_q;
    assign ped_walk      = ped_walk_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Directed bench for traffic_light_controller_param: expected phases are queued
// as each cycle of stimulus is driven and checked after the clock edge.
module tb_traffic_light_controller_param;

    localparam logic [2:0] S_HGRE  = 3'd0;
    localparam logic [2:0] S_HYEL  = 3'd1;
    localparam logic [2:0] S_ARED1 = 3'd2;
    localparam logic [2:0] S_FGRE  = 3'd3;
    localparam logic [2:0] S_FYEL  = 3'd4;
    localparam logic [2:0] S_ARED2 = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       walk;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sensor;
    logic       ped_req;
    logic       emergency;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       ped_walk;
    logic [2:0] state_o;

    exp_t sb[$];
    int   total;
    int   bad;

    traffic_light_controller_param dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor        (sensor),
        .ped_req       (ped_req),
        .emergency     (emergency),
        .light_highway (light_highway),
        .light_farm    (light_farm),
        .ped_walk      (ped_walk),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] hwy_of(input logic [2:0] st);
        case (st)
            S_HGRE:  return 3'b001;
            S_HYEL:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] farm_of(input logic [2:0] st);
        case (st)
            S_FGRE:  return 3'b001;
            S_FYEL:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty got=0 exp=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (state_o === e.st) else begin
                bad++;
                $error("FAIL %s state_o got=%0d exp=%0d", tag, state_o, e.st);
            end
            total++;
            assert (light_highway === hwy_of(e.st)) else begin
                bad++;
                $error("FAIL %s light_highway got=%b exp=%b", tag, light_highway, hwy_of(e.st));
            end
            total++;
            assert (light_farm === farm_of(e.st)) else begin
                bad++;
                $error("FAIL %s light_farm got=%b exp=%b", tag, light_farm, farm_of(e.st));
            end
            total++;
            assert (ped_walk === e.walk) else begin
                bad++;
                $error("FAIL %s ped_walk got=%b exp=%b", tag, ped_walk, e.walk);
            end
        end
        total++;
        assert (light_highway === 3'b100 || light_farm === 3'b100) else begin
            bad++;
            $error("FAIL %s both_heads_open got=%b/%b exp=one red", tag, light_highway, light_farm);
        end
    endtask

    // Drive n cycles of inputs; st/w is the expected phase after each edge
    task automatic run(input int n, input logic s, input logic p, input logic e,
                       input logic [2:0] st, input logic w, input string tag);
        for (int i = 0; i < n; i++) begin
            sensor    = s;
            ped_req   = p;
            emergency = e;
            sb.push_back('{st: st, walk: w});
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic do_reset(input int n, input string tag);
        rst_n     = 1'b0;
        sensor    = 1'b0;
        ped_req   = 1'b0;
        emergency = 1'b0;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{st: S_HGRE, walk: 1'b0});
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i));
        end
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        sensor    = 1'b0;
        ped_req   = 1'b0;
        emergency = 1'b0;

        // Reset values, then idle highway with no demand
        do_reset(10, "reset");
        run(100, 1'b0, 1'b0, 1'b0, S_HGRE, 1'b0, "idle");

        // Sensor held from release: full cycle at default timing
        do_reset(2, "rst_a");
        run(19, 1'b1, 1'b0, 1'b0, S_HGRE,  1'b0, "full_hgre");
        run(3,  1'b1, 1'b0, 1'b0, S_HYEL,  1'b0, "full_hyel");
        run(1,  1'b1, 1'b0, 1'b0, S_ARED1, 1'b0, "full_ared1");
        run(10, 1'b1, 1'b0, 1'b0, S_FGRE,  1'b0, "full_fgre");
        run(3,  1'b1, 1'b0, 1'b0, S_FYEL,  1'b0, "full_fyel");
        run(1,  1'b1, 1'b0, 1'b0, S_ARED2, 1'b0, "full_ared2");
        run(3,  1'b1, 1'b0, 1'b0, S_HGRE,  1'b0, "full_hgre2");

        // Short sensor pulse early in highway green is not remembered
        do_reset(2, "rst_b");
        run(5,  1'b0, 1'b0, 1'b0, S_HGRE, 1'b0, "nolatch_pre");
        run(1,  1'b1, 1'b0, 1'b0, S_HGRE, 1'b0, "nolatch_pulse");
        run(30, 1'b0, 1'b0, 1'b0, S_HGRE, 1'b0, "nolatch_post");

        // Sensor from cycle 5, drops in the second farm-green cycle
        do_reset(2, "rst_c");
        run(5,  1'b0, 1'b0, 1'b0, S_HGRE,  1'b0, "pulse_pre");
        run(14, 1'b1, 1'b0, 1'b0, S_HGRE,  1'b0, "pulse_hgre");
        run(3,  1'b1, 1'b0, 1'b0, S_HYEL,  1'b0, "pulse_hyel");
        run(1,  1'b1, 1'b0, 1'b0, S_ARED1, 1'b0, "pulse_ared1");
        run(2,  1'b1, 1'b0, 1'b0, S_FGRE,  1'b0, "pulse_fgre");
        run(2,  1'b0, 1'b0, 1'b0, S_FYEL,  1'b0, "pulse_fyel");

        // Asynchronous reset between edges while in farm yellow
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{st: S_HGRE, walk: 1'b0});
        check("async_rst");
        #1;
        rst_n = 1'b1;
        run(19, 1'b1, 1'b0, 1'b0, S_HGRE, 1'b0, "fresh_hgre");
        run(1,  1'b1, 1'b0, 1'b0, S_HYEL, 1'b0, "fresh_hyel");

        // Pedestrian request alone earns a full walk phase
        do_reset(2, "rst_d");
        run(3,  1'b0, 1'b0, 1'b0, S_HGRE,  1'b0, "ped_pre");
        run(1,  1'b0, 1'b1, 1'b0, S_HGRE,  1'b0, "ped_req");
        run(15, 1'b0, 1'b0, 1'b0, S_HGRE,  1'b0, "ped_hgre");
        run(3,  1'b0, 1'b0, 1'b0, S_HYEL,  1'b0, "ped_hyel");
        run(1,  1'b0, 1'b0, 1'b0, S_ARED1, 1'b0, "ped_ared1");
        run(10, 1'b0, 1'b0, 1'b0, S_FGRE,  1'b1, "ped_fgre");
        run(3,  1'b0, 1'b0, 1'b0, S_FYEL,  1'b0, "ped_fyel");
        run(1,  1'b0, 1'b0, 1'b0, S_ARED2, 1'b0, "ped_ared2");
        run(5,  1'b0, 1'b0, 1'b0, S_HGRE,  1'b0, "ped_hgre2");

        // Emergency in farm green forces highway and holds it
        do_reset(2, "rst_e");
        run(19, 1'b1, 1'b0, 1'b0, S_HGRE,  1'b0, "emg_hgre");
        run(3,  1'b1, 1'b0, 1'b0, S_HYEL,  1'b0, "emg_hyel");
        run(1,  1'b1, 1'b0, 1'b0, S_ARED1, 1'b0, "emg_ared1");
        run(2,  1'b1, 1'b0, 1'b0, S_FGRE,  1'b0, "emg_fgre");
        run(3,  1'b1, 1'b0, 1'b1, S_FYEL,  1'b0, "emg_fyel");
        run(1,  1'b1, 1'b0, 1'b1, S_ARED2, 1'b0, "emg_ared2");
        run(30, 1'b1, 1'b0, 1'b1, S_HGRE,  1'b0, "emg_hold");
        run(1,  1'b1, 1'b0, 1'b0, S_HYEL,  1'b0, "emg_release");

        // Emergency during highway yellow: yellow completes, then back to green
        do_reset(2, "rst_f");
        run(19, 1'b1, 1'b0, 1'b0, S_HGRE,  1'b0, "emy_hgre");
        run(1,  1'b1, 1'b0, 1'b0, S_HYEL,  1'b0, "emy_hyel0");
        run(2,  1'b1, 1'b0, 1'b1, S_HYEL,  1'b0, "emy_hyel");
        run(1,  1'b1, 1'b0, 1'b1, S_ARED1, 1'b0, "emy_ared1");
        run(3,  1'b1, 1'b0, 1'b1, S_HGRE,  1'b0, "emy_hgre2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
